mapper_mem_bridge: RTL and testbench

Sequencer that sits directly downstream of the cartridge mapper stage. It takes the mapper's resolved chip selects and 27-bit address for each CPU bus request, runs the access against the SDRAM port (req/ack handshake) or the on-chip SRAM/BRAM port (fixed one-cycle read latency), and holds CPU wait until the data is ready. It also returns 0xFF for unmapped reads, and returns 0xFF with a timeout flag if SDRAM never acknowledges.

---
 rtl/mapper_mem_bridge_pkg.sv | 30 +++
 rtl/mapper_mem_bridge_if.sv | 68 ++++++
 rtl/mapper_mem_bridge.sv | 150 +++++++++++++++
 tb/tb_mapper_mem_bridge.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mapper_mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mapper_mem_bridge_pkg
// Purpose  : Shared mapper package. Holds the bridge state type, the unmapped
//            address marker, the open-bus value and a saturating counter step.
// Revision : 1.0 - initial release
// ============================================================================
package mapper_mem_bridge_pkg;

  // Sequencer states of the mapper-to-memory bridge
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM     = 2'd1,
    SRAM_RD = 2'd2,
    DONE    = 2'd3
  } bridge_state_t;

  // Mapper address value that marks an unmapped CPU access
  localparam logic [26:0] UNMAPPED_ADDR = 27'h7FFFFFF;

  // Value returned on reads that hit nothing or that timed out
  localparam logic [7:0]  OPEN_BUS      = 8'hFF;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mapper_mem_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : mapper_mem_bridge_if
// Purpose  : Bundle of the CPU/mapper request side, the SDRAM req/ack port and
//            the SRAM port seen by the bridge. The bridge uses the slave
//            modport; the surrounding system (CPU, mapper, memories) uses the
//            master modport.
// Revision : 1.0 - initial release
// ============================================================================
interface mapper_mem_bridge_if #(
  parameter int SRAM_AW = 18
) ();

  // CPU and mapper request side
  logic               cpu_req;
  logic               cpu_rd;
  logic               cpu_wr;
  logic [7:0]         cpu_din;
  logic               map_ram_cs;
  logic               map_sram_cs;
  logic               map_rnw;
  logic [26:0]        map_addr;
  logic               cpu_wait;
  logic [7:0]         cpu_dout;
  logic               cpu_dvalid;

  // SDRAM request/acknowledge port
  logic               ram_req;
  logic               ram_we;
  logic [26:0]        ram_addr;
  logic [7:0]         ram_din;
  logic               ram_ack;
  logic [7:0]         ram_dout;

  // On-chip SRAM port
  logic               sram_we;
  logic [SRAM_AW-1:0] sram_addr;
  logic [7:0]         sram_din;
  logic [7:0]         sram_dout;

  // Status
  logic               err_timeout;
  logic               err_overrun;

  modport slave (
    input  cpu_req, cpu_rd, cpu_wr, cpu_din,
    input  map_ram_cs, map_sram_cs, map_rnw, map_addr,
    output cpu_wait, cpu_dout, cpu_dvalid,
    output ram_req, ram_we, ram_addr, ram_din,
    input  ram_ack, ram_dout,
    output sram_we, sram_addr, sram_din,
    input  sram_dout,
    output err_timeout, err_overrun
  );

  modport master (
    output cpu_req, cpu_rd, cpu_wr, cpu_din,
    output map_ram_cs, map_sram_cs, map_rnw, map_addr,
    input  cpu_wait, cpu_dout, cpu_dvalid,
    input  ram_req, ram_we, ram_addr, ram_din,
    output ram_ack, ram_dout,
    input  sram_we, sram_addr, sram_din,
    output sram_dout,
    input  err_timeout, err_overrun
  );

endinterface
`default_nettype wire

// File: rtl/mapper_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mapper_mem_bridge
// Purpose  : Runs each mapped CPU access against SDRAM (req/ack) or on-chip
//            SRAM (one-cycle read latency), stalls the CPU until read data is
//            ready, returns open-bus for unmapped reads and abandons SDRAM
//            accesses that are never acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module mapper_mem_bridge
  import mapper_mem_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int SRAM_AW = 18
) (
  input  logic                clk,
  input  logic                reset_n,
  mapper_mem_bridge_if.slave  bus
);

  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  bridge_state_t      state_q;
  logic [15:0]        cnt_q;
  logic [15:0]        cnt_d;
  logic [7:0]         cpu_dout_q;
  logic               cpu_dvalid_q;
  logic               ram_req_q;
  logic               ram_we_q;
  logic [26:0]        ram_addr_q;
  logic [7:0]         ram_din_q;
  logic               sram_we_q;
  logic [SRAM_AW-1:0] sram_addr_q;
  logic [7:0]         sram_din_q;
  logic               err_timeout_q;
  logic               err_overrun_q;
  logic               we_d;
  logic               wait_idle_d;

  // Write qualifier and the zero-latency stall raised while still in IDLE
  always_comb begin
    we_d        = bus.cpu_wr & ~bus.map_rnw;
    wait_idle_d = (state_q == IDLE) & bus.cpu_req &
                  (bus.map_ram_cs | (bus.map_sram_cs & bus.cpu_rd));
    cnt_d       = sat_inc16(cnt_q);
  end

  // Access sequencer: dispatch, SDRAM handshake with timeout, SRAM read, done
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cpu_dout_q    <= OPEN_BUS;
      cpu_dvalid_q  <= 1'b0;
      ram_req_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      sram_we_q     <= 1'b0;
      sram_addr_q   <= '0;
      sram_din_q    <= '0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      cpu_dvalid_q  <= 1'b0;
      sram_we_q     <= 1'b0;
      // A request while busy is dropped; flag it on the following cycle
      err_overrun_q <= bus.cpu_req & (state_q != IDLE);

      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            if (bus.map_sram_cs) begin
              // SRAM wins when both selects are asserted
              sram_addr_q <= bus.map_addr[SRAM_AW-1:0];
              sram_din_q  <= bus.cpu_din;
              if (we_d) begin
                sram_we_q <= 1'b1;
              end else begin
                state_q   <= SRAM_RD;
              end
            end else if (bus.map_ram_cs) begin
              ram_req_q  <= 1'b1;
              ram_we_q   <= we_d;
              ram_addr_q <= bus.map_addr;
              ram_din_q  <= bus.cpu_din;
              cnt_q      <= '0;
              state_q    <= RAM;
            end else if (!we_d) begin
              // Unmapped read answers open-bus immediately
              cpu_dout_q   <= OPEN_BUS;
              cpu_dvalid_q <= 1'b1;
              state_q      <= DONE;
            end
          end
        end

        RAM: begin
          if (bus.ram_ack) begin
            // An ack on the final counted cycle still wins over the timeout
            ram_req_q <= 1'b0;
            if (!ram_we_q) begin
              cpu_dout_q   <= bus.ram_dout;
              cpu_dvalid_q <= 1'b1;
            end
            state_q <= DONE;
          end else if (cnt_d >= c_TIMEOUT) begin
            ram_req_q     <= 1'b0;
            err_timeout_q <= 1'b1;
            cpu_dout_q    <= OPEN_BUS;
            cpu_dvalid_q  <= ~ram_we_q;
            cnt_q         <= cnt_d;
            state_q       <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        SRAM_RD: begin
          cpu_dout_q   <= bus.sram_dout;
          cpu_dvalid_q <= 1'b1;
          state_q      <= DONE;
        end

        DONE: begin
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_wait    = wait_idle_d | (state_q == RAM) | (state_q == SRAM_RD);
  assign bus.cpu_dout    = cpu_dout_q;
  assign bus.cpu_dvalid  = cpu_dvalid_q;
  assign bus.ram_req     = ram_req_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.sram_we     = sram_we_q;
  assign bus.sram_addr   = sram_addr_q;
  assign bus.sram_din    = sram_din_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_mapper_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mapper_mem_bridge
// Purpose  : Self-checking bench for mapper_mem_bridge. Directed scenarios
//            followed by randomized transactions, each predicted by a
//            transaction-level model of the bridge's rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mapper_mem_bridge;
  import mapper_mem_bridge_pkg::*;

  localparam int TMO = 4;
  localparam int AW  = 18;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mapper_mem_bridge_if #(.SRAM_AW(AW)) bus ();

  mapper_mem_bridge #(.TIMEOUT(TMO), .SRAM_AW(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Behavioural 8K SRAM device: one-cycle write, read data follows address
  logic [7:0] dev_mem [0:8191];
  always @(posedge clk) begin
    if (bus.sram_we) dev_mem[bus.sram_addr[12:0]] <= bus.sram_din;
  end
  assign bus.sram_dout = dev_mem[bus.sram_addr[12:0]];

  // Reference model state
  logic [7:0]  ref_mem [0:8191];
  logic [26:0] written_q[$];
  logic [7:0]  exp_dout;
  logic        exp_tmo;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.cpu_req     = 1'b0;
    bus.cpu_rd      = 1'b0;
    bus.cpu_wr      = 1'b0;
    bus.cpu_din     = 8'h00;
    bus.map_ram_cs  = 1'b0;
    bus.map_sram_cs = 1'b0;
    bus.map_rnw     = 1'b1;
    bus.map_addr    = '0;
    bus.ram_ack     = 1'b0;
  endtask

  task automatic drive_req(input logic ram_cs, input logic sram_cs, input logic wr,
                           input logic [26:0] addr, input logic [7:0] din);
    bus.cpu_req     = 1'b1;
    bus.cpu_rd      = ~wr;
    bus.cpu_wr      = wr;
    bus.map_rnw     = ~wr;
    bus.cpu_din     = din;
    bus.map_ram_cs  = ram_cs;
    bus.map_sram_cs = sram_cs;
    bus.map_addr    = addr;
    bus.ram_ack     = 1'b0;
  endtask

  // Stray request while the bridge is busy; contents are irrelevant
  task automatic inject_req();
    drive_req(1'($urandom), 1'($urandom), 1'($urandom), 27'($urandom), 8'($urandom));
  endtask

  // SDRAM access: d = cycle offset of ack (0 = never), inj = cycle offset of a stray request (0 = none)
  task automatic do_ram(input logic wr, input logic [26:0] addr, input logic [7:0] wdata,
                        input int d, input logic [7:0] rdata, input int inj);
    bit acked;
    int last;
    acked = (d >= 1) && (d <= TMO);
    last  = acked ? d : TMO;
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, wr, addr, wdata);
    @(negedge clk);
    check_eq("ram_wait_T", 32'(bus.cpu_wait), 32'd1);
    for (int k = 1; k <= last + 1; k++) begin
      @(posedge clk); #1;
      idle_inputs();
      if (k == inj) inject_req();
      bus.ram_ack  = acked && (k == d);
      bus.ram_dout = (acked && (k == d)) ? rdata : 8'($urandom);
      @(negedge clk);
      check_eq("ram_overrun", 32'(bus.err_overrun), 32'((inj != 0) && (k == inj + 1)));
      if (k <= last) begin
        check_eq("ram_req_hi", 32'(bus.ram_req),  32'd1);
        check_eq("ram_addr",   32'(bus.ram_addr), 32'(addr));
        check_eq("ram_we",     32'(bus.ram_we),   32'(wr));
        if (wr) check_eq("ram_din", 32'(bus.ram_din), 32'(wdata));
        check_eq("ram_wait",   32'(bus.cpu_wait),   32'd1);
        check_eq("ram_dv_lo",  32'(bus.cpu_dvalid), 32'd0);
      end else begin
        if (!acked) begin
          exp_tmo  = 1'b1;
          exp_dout = OPEN_BUS;
        end else if (!wr) begin
          exp_dout = rdata;
        end
        check_eq("ram_req_lo",  32'(bus.ram_req),     32'd0);
        check_eq("ram_wait_rl", 32'(bus.cpu_wait),    32'd0);
        check_eq("ram_dvalid",  32'(bus.cpu_dvalid),  32'(!wr));
        check_eq("ram_dout",    32'(bus.cpu_dout),    32'(exp_dout));
        check_eq("ram_tmo",     32'(bus.err_timeout), 32'(exp_tmo));
      end
    end
  endtask

  task automatic do_sram_wr(input logic [26:0] addr, input logic [7:0] din);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 1'b1, addr, din);
    @(negedge clk);
    check_eq("sw_wait_T", 32'(bus.cpu_wait), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check_eq("sw_we",    32'(bus.sram_we),   32'd1);
    check_eq("sw_addr",  32'(bus.sram_addr), 32'(addr[AW-1:0]));
    check_eq("sw_din",   32'(bus.sram_din),  32'(din));
    check_eq("sw_wait",  32'(bus.cpu_wait),  32'd0);
    check_eq("sw_noreq", 32'(bus.ram_req),   32'd0);
    ref_mem[addr[12:0]] = din;
    written_q.push_back(addr);
  endtask

  task automatic do_sram_rd(input logic [26:0] addr, input logic both_cs, input bit inj);
    @(posedge clk); #1;
    drive_req(both_cs, 1'b1, 1'b0, addr, 8'($urandom));
    @(negedge clk);
    check_eq("sr_wait_T", 32'(bus.cpu_wait), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    if (inj) inject_req();
    @(negedge clk);
    check_eq("sr_wait_T1", 32'(bus.cpu_wait),   32'd1);
    check_eq("sr_addr",    32'(bus.sram_addr),  32'(addr[AW-1:0]));
    check_eq("sr_noreq",   32'(bus.ram_req),    32'd0);
    check_eq("sr_dv_lo",   32'(bus.cpu_dvalid), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    exp_dout = ref_mem[addr[12:0]];
    check_eq("sr_dvalid",  32'(bus.cpu_dvalid),  32'd1);
    check_eq("sr_dout",    32'(bus.cpu_dout),    32'(exp_dout));
    check_eq("sr_wait_rl", 32'(bus.cpu_wait),    32'd0);
    check_eq("sr_overrun", 32'(bus.err_overrun), 32'(inj));
  endtask

  task automatic do_unmapped(input logic wr);
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, wr, UNMAPPED_ADDR, 8'($urandom));
    @(negedge clk);
    check_eq("um_wait_T", 32'(bus.cpu_wait), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    if (!wr) exp_dout = OPEN_BUS;
    check_eq("um_dvalid", 32'(bus.cpu_dvalid), 32'(!wr));
    check_eq("um_dout",   32'(bus.cpu_dout),   32'(exp_dout));
    check_eq("um_wait",   32'(bus.cpu_wait),   32'd0);
    check_eq("um_noreq",  32'(bus.ram_req),    32'd0);
    check_eq("um_nowe",   32'(bus.sram_we),    32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wait"},  32'(bus.cpu_wait),    32'd0);
    check_eq({tag, "_dv"},    32'(bus.cpu_dvalid),  32'd0);
    check_eq({tag, "_dout"},  32'(bus.cpu_dout),    32'(OPEN_BUS));
    check_eq({tag, "_req"},   32'(bus.ram_req),     32'd0);
    check_eq({tag, "_rwe"},   32'(bus.ram_we),      32'd0);
    check_eq({tag, "_raddr"}, 32'(bus.ram_addr),    32'd0);
    check_eq({tag, "_rdin"},  32'(bus.ram_din),     32'd0);
    check_eq({tag, "_swe"},   32'(bus.sram_we),     32'd0);
    check_eq({tag, "_saddr"}, 32'(bus.sram_addr),   32'd0);
    check_eq({tag, "_sdin"},  32'(bus.sram_din),    32'd0);
    check_eq({tag, "_tmo"},   32'(bus.err_timeout), 32'd0);
    check_eq({tag, "_ovr"},   32'(bus.err_overrun), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    exp_dout = OPEN_BUS;
    exp_tmo  = 1'b0;
    idle_inputs();
    bus.ram_dout = 8'h00;

    // Reset held two cycles with a toggling ack
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      bus.ram_ack = ~bus.ram_ack;
    end
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    bus.ram_ack = 1'b0;
    reset_n     = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_dv", 32'(bus.cpu_dvalid), 32'd0);

    // Directed scenarios
    do_ram(1'b0, 27'h0014000, 8'h00, 3, 8'h5A, 0);
    do_sram_wr(27'h0001FFF, 8'hC3);
    do_sram_rd(27'h0001FFF, 1'b0, 1'b0);
    do_ram(1'b0, 27'h0123456, 8'h00, 0, 8'h00, 0);        // timeout
    do_ram(1'b0, 27'h0000FF0, 8'h00, TMO, 8'h3C, 0);      // ack on the last counted cycle
    do_unmapped(1'b0);
    do_unmapped(1'b1);
    do_ram(1'b0, 27'h0200000, 8'h00, 3, 8'h77, 1);        // overrun during RAM
    do_sram_rd(27'h0001FFF, 1'b1, 1'b1);                   // both cs, overrun

    // Reset in the middle of an SDRAM access, followed by a late ack
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 1'b0, 27'h0300000, 8'h00);
    @(posedge clk); #1;
    idle_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("mid_req_before", 32'(bus.ram_req), 32'd1);
    @(posedge clk); #1;
    reset_n      = 1'b1;
    bus.ram_ack  = 1'b1;
    bus.ram_dout = 8'h99;
    exp_tmo  = 1'b0;
    exp_dout = OPEN_BUS;
    @(negedge clk);
    check_reset_outputs("mid");
    @(posedge clk); #1;
    bus.ram_ack = 1'b0;
    @(negedge clk);
    check_eq("late_ack_dv",   32'(bus.cpu_dvalid), 32'd0);
    check_eq("late_ack_req",  32'(bus.ram_req),    32'd0);
    check_eq("late_ack_dout", 32'(bus.cpu_dout),   32'(OPEN_BUS));

    // Randomized transactions
    for (int n = 0; n < 200; n++) begin
      int kind;
      kind = $urandom_range(0, 5);
      if (kind == 1 && written_q.size() == 0) kind = 0;
      case (kind)
        0: do_sram_wr({14'($urandom), 13'($urandom)}, 8'($urandom));
        1: do_sram_rd(written_q[$urandom_range(0, written_q.size() - 1)],
                      1'($urandom), ($urandom_range(0, 3) == 0));
        2, 3: begin
          int d;
          int lst;
          int inj;
          d   = $urandom_range(0, 6);
          lst = (d >= 1 && d <= TMO) ? d : TMO;
          inj = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lst) : 0;
          do_ram(1'($urandom), 27'($urandom), 8'($urandom), d, 8'($urandom), inj);
        end
        4: do_unmapped(1'b0);
        default: do_unmapped(1'b1);
      endcase
      // Occasional idle gap with a stray ack that must be ignored
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk); #1;
        idle_inputs();
        bus.ram_ack = 1'($urandom);
        @(negedge clk);
        check_eq("gap_dv",  32'(bus.cpu_dvalid), 32'd0);
        check_eq("gap_req", 32'(bus.ram_req),    32'd0);
        @(posedge clk); #1;
        bus.ram_ack = 1'b0;
        @(negedge clk);
        check_eq("gap_dv2",  32'(bus.cpu_dvalid), 32'd0);
        check_eq("gap_dout", 32'(bus.cpu_dout),   32'(exp_dout));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
